// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one physical memory port between fetch (I) and
// memory-stage data (D) requesters. Data has priority because it belongs to
// the older instruction. A streak counter hands the port to a waiting fetch
// after MAX_D_STREAK consecutive data grants. Grants are registered, and the
// granted request is latched so pmem outputs hold steady for the whole access.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   IDLE    | arbitration cycle; grant latches request, pmem strobes low
//   SERVE_I | fetch read in flight; pmem_resp forwarded to i_resp
//   SERVE_D | data read/write in flight; pmem_resp forwarded to d_resp
module mem_port_arbiter #(
  parameter int DATA_W       = 16,
  parameter int MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_read,
  input  logic [DATA_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [1:0]        d_wmask,
  input  logic [DATA_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [1:0]        pmem_wmask,
  output logic [DATA_W-1:0] pmem_addr,
  output logic [DATA_W-1:0] pmem_wdata,
  input  logic [DATA_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  // A zero MAX_D_STREAK still needs a 1-bit counter; it simply never leaves 0.
  localparam int STREAK_W = (MAX_D_STREAK < 1) ? 1 : $clog2(MAX_D_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);
  localparam bit OVERRIDE_EN = (MAX_D_STREAK != 0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arbState_t;

  arbState_t           state;
  arbState_t           stateNext;
  logic                grantI;
  logic                grantD;
  logic                dPending;
  logic [STREAK_W-1:0] dStreak;
  logic [DATA_W-1:0]   latAddr;
  logic [DATA_W-1:0]   latWdata;
  logic [1:0]          latWmask;
  logic                latRead;
  logic                latWrite;
  logic                serving;

  assign dPending = d_read | d_write;
  assign serving  = (state != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Arbitration in IDLE and completion detection while serving.
  always_comb begin
    stateNext = state;
    grantI    = 1'b0;
    grantD    = 1'b0;
    unique case (state)
      IDLE: begin
        if (dPending && i_read) begin
          if (OVERRIDE_EN && (dStreak == STREAK_MAX)) begin
            grantI = 1'b1;
          end else begin
            grantD = 1'b1;
          end
        end else if (dPending) begin
          grantD = 1'b1;
        end else if (i_read) begin
          grantI = 1'b1;
        end
        if (grantI) begin
          stateNext = SERVE_I;
        end else if (grantD) begin
          stateNext = SERVE_D;
        end
      end
      SERVE_I: begin
        if (pmem_resp) begin
          stateNext = IDLE;
        end
      end
      SERVE_D: begin
        if (pmem_resp) begin
          stateNext = IDLE;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Capture the granted request and its op; write wins over read for D.
  always_ff @(posedge clk) begin
    if (reset) begin
      latAddr  <= '0;
      latWdata <= '0;
      latWmask <= '0;
      latRead  <= 1'b0;
      latWrite <= 1'b0;
    end else if (grantI) begin
      latAddr  <= i_addr;
      latRead  <= 1'b1;
      latWrite <= 1'b0;
    end else if (grantD) begin
      latAddr  <= d_addr;
      latWdata <= d_wdata;
      latWmask <= d_wmask;
      latRead  <= d_read & ~d_write;
      latWrite <= d_write;
    end
  end

  // Count data grants that made a fetch wait; saturates at the limit.
  always_ff @(posedge clk) begin
    if (reset) begin
      dStreak <= '0;
    end else if (grantI) begin
      dStreak <= '0;
    end else if (grantD) begin
      if (!i_read) begin
        dStreak <= '0;
      end else if (dStreak != STREAK_MAX) begin
        dStreak <= dStreak + STREAK_W'(1);
      end
    end
  end

  // Strobes only while serving, so they drop the cycle after completion.
  always_comb begin
    pmem_read  = latRead & serving;
    pmem_write = latWrite & serving;
    pmem_wmask = latWmask;
    pmem_addr  = latAddr;
    pmem_wdata = latWdata;
    i_resp     = (state == SERVE_I) & pmem_resp;
    d_resp     = (state == SERVE_D) & pmem_resp;
    i_rdata    = pmem_rdata;
    d_rdata    = pmem_rdata;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (MAX_D_STREAK=2). Inputs change at
// negedge or #1 after posedge; outputs are sampled at negedge.
module tb_mem_port_arbiter;

  localparam int DATA_W = 16;

  logic              clk;
  logic              reset;
  logic              i_read;
  logic [DATA_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read;
  logic              d_write;
  logic [1:0]        d_wmask;
  logic [DATA_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic [1:0]        pmem_wmask;
  logic [DATA_W-1:0] pmem_addr;
  logic [DATA_W-1:0] pmem_wdata;
  logic [DATA_W-1:0] pmem_rdata;
  logic              pmem_resp;

  int total = 0;
  int bad   = 0;

  mem_port_arbiter #(.DATA_W(DATA_W), .MAX_D_STREAK(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .i_read     (i_read),
    .i_addr     (i_addr),
    .i_rdata    (i_rdata),
    .i_resp     (i_resp),
    .d_read     (d_read),
    .d_write    (d_write),
    .d_wmask    (d_wmask),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_rdata    (d_rdata),
    .d_resp     (d_resp),
    .pmem_read  (pmem_read),
    .pmem_write (pmem_write),
    .pmem_wmask (pmem_wmask),
    .pmem_addr  (pmem_addr),
    .pmem_wdata (pmem_wdata),
    .pmem_rdata (pmem_rdata),
    .pmem_resp  (pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge in IDLE with requests already presented: expects a
  // read grant on the next edge, answers it after one cycle, drops the served
  // request, and ends at the negedge of the following IDLE cycle.
  task automatic serveOne(input bit expI, input logic [15:0] expAddr,
                          input logic [15:0] rd, input string tag);
    @(negedge clk);
    check({tag, " strobes"}, {30'd0, pmem_read, pmem_write}, 32'd2);
    check({tag, " addr"}, pmem_addr, expAddr);
    check({tag, " no early resp"}, {30'd0, i_resp, d_resp}, 32'd0);
    @(posedge clk); #1;
    pmem_resp  = 1'b1;
    pmem_rdata = rd;
    @(negedge clk);
    check({tag, " i_resp"}, i_resp, expI);
    check({tag, " d_resp"}, d_resp, !expI);
    check({tag, " rdata"}, expI ? i_rdata : d_rdata, rd);
    @(posedge clk); #1;
    pmem_resp = 1'b0;
    if (expI) i_read = 1'b0;
    else      d_read = 1'b0;
    @(negedge clk);
    check({tag, " idle strobes"}, {30'd0, pmem_read, pmem_write}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    i_read = 0; i_addr = 0; d_read = 0; d_write = 0; d_wmask = 0;
    d_addr = 0; d_wdata = 0; pmem_rdata = 0; pmem_resp = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst strobes", {30'd0, pmem_read, pmem_write}, 32'd0);
    check("rst resps", {30'd0, i_resp, d_resp}, 32'd0);
    check("rst addr", pmem_addr, 32'd0);
    check("rst wdata", pmem_wdata, 32'd0);
    check("rst wmask", pmem_wmask, 32'd0);
    reset = 1'b0;

    // I-only read, response three cycles after grant.
    i_read = 1'b1; i_addr = 16'h3000;
    @(negedge clk);
    check("i1 read", pmem_read, 1);
    check("i1 write", pmem_write, 0);
    check("i1 addr", pmem_addr, 32'h3000);
    check("i1 no resp", {30'd0, i_resp, d_resp}, 32'd0);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      i_addr = 16'h3FFF;
      @(negedge clk);
      check("i1 hold read", pmem_read, 1);
      check("i1 hold addr", pmem_addr, 32'h3000);
    end
    @(posedge clk); #1;
    pmem_resp = 1'b1; pmem_rdata = 16'h1234;
    @(negedge clk);
    check("i1 i_resp", i_resp, 1);
    check("i1 i_rdata", i_rdata, 32'h1234);
    check("i1 d_resp", d_resp, 0);
    @(posedge clk); #1;
    pmem_resp = 1'b0; i_read = 1'b0;
    @(negedge clk);
    check("i1 after resp", {30'd0, i_resp, pmem_read}, 32'd0);

    // D write (d_read also high: write must win), address changed mid-flight.
    d_write = 1'b1; d_read = 1'b1; d_addr = 16'h4001; d_wdata = 16'hAB00; d_wmask = 2'b10;
    @(negedge clk);
    check("dw write", pmem_write, 1);
    check("dw read", pmem_read, 0);
    check("dw wmask", pmem_wmask, 32'h2);
    check("dw wdata", pmem_wdata, 32'hAB00);
    check("dw addr", pmem_addr, 32'h4001);
    @(posedge clk); #1;
    d_addr = 16'h5555; d_wdata = 16'h0F0F; d_wmask = 2'b01;
    @(negedge clk);
    check("dw hold addr", pmem_addr, 32'h4001);
    check("dw hold wdata", pmem_wdata, 32'hAB00);
    check("dw hold wmask", pmem_wmask, 32'h2);
    @(posedge clk); #1;
    pmem_resp = 1'b1;
    @(negedge clk);
    check("dw d_resp", d_resp, 1);
    check("dw i_resp", i_resp, 0);
    check("dw addr at resp", pmem_addr, 32'h4001);
    @(posedge clk); #1;
    pmem_resp = 1'b0; d_write = 1'b0; d_read = 1'b0;
    @(negedge clk);
    check("dw after resp", {30'd0, d_resp, pmem_write}, 32'd0);

    // pmem_resp while IDLE is ignored.
    pmem_resp = 1'b1;
    @(negedge clk);
    check("idle resp ignored", {30'd0, i_resp, d_resp}, 32'd0);
    pmem_resp = 1'b0;
    @(negedge clk);
    check("idle resp no strobe", {30'd0, pmem_read, pmem_write}, 32'd0);

    // Simultaneous: D first, then I in the arbitration cycle after d_resp.
    i_read = 1'b1; i_addr = 16'h3100; d_read = 1'b1; d_addr = 16'h4100;
    serveOne(1'b0, 16'h4100, 16'h1111, "sim D");
    serveOne(1'b1, 16'h3100, 16'h2222, "sim I");

    // Starvation: both re-asserted each round, expect D, D, I, D, D, I.
    i_addr = 16'h3200; d_addr = 16'h4200;
    i_read = 1'b1; d_read = 1'b1;
    serveOne(1'b0, 16'h4200, 16'h0A01, "stv1 D");
    i_read = 1'b1; d_read = 1'b1;
    serveOne(1'b0, 16'h4200, 16'h0A02, "stv2 D");
    i_read = 1'b1; d_read = 1'b1;
    serveOne(1'b1, 16'h3200, 16'h0A03, "stv3 I");
    i_read = 1'b1; d_read = 1'b1;
    serveOne(1'b0, 16'h4200, 16'h0A04, "stv4 D");
    i_read = 1'b1; d_read = 1'b1;
    serveOne(1'b0, 16'h4200, 16'h0A05, "stv5 D");
    i_read = 1'b1; d_read = 1'b1;
    serveOne(1'b1, 16'h3200, 16'h0A06, "stv6 I");
    i_read = 1'b0; d_read = 1'b0;

    // Reset during SERVE_D (streak at 1), late pmem_resp, then normal arbitration.
    i_read = 1'b1; i_addr = 16'h3300; d_read = 1'b1; d_addr = 16'h4300;
    @(negedge clk);
    check("rm read", pmem_read, 1);
    check("rm addr", pmem_addr, 32'h4300);
    @(posedge clk); #1;
    reset = 1'b1; i_read = 1'b0; d_read = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0; pmem_resp = 1'b1;
    @(negedge clk);
    check("rm strobe low", {30'd0, pmem_read, pmem_write}, 32'd0);
    check("rm late resp", {30'd0, i_resp, d_resp}, 32'd0);
    check("rm addr cleared", pmem_addr, 32'd0);
    @(posedge clk); #1;
    pmem_resp = 1'b0;
    @(negedge clk);
    check("rm still idle", {30'd0, pmem_read, pmem_write}, 32'd0);
    i_read = 1'b1; d_read = 1'b1;
    serveOne(1'b0, 16'h4300, 16'h0B01, "post D1");
    d_read = 1'b1;
    serveOne(1'b0, 16'h4300, 16'h0B02, "post D2");
    d_read = 1'b1;
    serveOne(1'b1, 16'h3300, 16'h0B03, "post I");
    i_read = 1'b0; d_read = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
